// File: rtl/ram_ctrl.sv
// ram_ctrl: parametrised single-port data memory with a memio/ready handshake,
// programmable wait states, optional zero-fill after reset and out-of-range error flag.
module ram_ctrl #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned WAIT_STATES    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memio,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int unsigned    PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [3:0]     WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StClear, StIdle, StWait, StDone} state_e;

  localparam state_e StReset = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Next-state logic: clear sweep, request capture, wait countdown, completion.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PtrLast) begin
          ptr_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (memio) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = data_in;
          cnt_d   = WaitInit;
          state_d = (WAIT_STATES == 0) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StReset;
      end
    endcase
    // Read data is registered on the edge that enters DONE so it lines up with ready.
    if (state_d == StDone && state_q != StDone && rw_d) begin
      dout_d = in_range(addr_d) ? mem_q[addr_d[PtrW-1:0]] : '0;
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReset;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array: zero-fill during clear, commit in-range writes when DONE; reset aborts both.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem_q[ptr_q] <= '0;
      end else if (state_q == StDone && !rw_q && in_range(addr_q)) begin
        mem_q[addr_q[PtrW-1:0]] <= wdata_q;
      end
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    ready    = (state_q == StDone);
    err      = (state_q == StDone) && !in_range(addr_q);
    busy     = (state_q != StIdle);
    data_out = dout_q;
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: three ram_ctrl configurations checked against an array-based reference model.
module tb_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        memio_s [3];
  logic        rw_s    [3];
  logic [7:0]  addr_s  [3];
  logic [15:0] din_s   [3];
  logic        ready_s [3];
  logic        err_s   [3];
  logic        busy_s  [3];
  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain word arrays plus the last value read per instance.
  logic [15:0] mdl     [3][256];
  logic [15:0] last_rd [3];

  ram_ctrl u_dut0 (
    .clk(clk), .rst(rst), .memio(memio_s[0]), .rw(rw_s[0]), .addr(addr_s[0]),
    .data_in(din_s[0][7:0]), .data_out(dout0), .ready(ready_s[0]), .err(err_s[0]),
    .busy(busy_s[0])
  );

  ram_ctrl #(.DEPTH(200), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst), .memio(memio_s[1]), .rw(rw_s[1]), .addr(addr_s[1]),
    .data_in(din_s[1][7:0]), .data_out(dout1), .ready(ready_s[1]), .err(err_s[1]),
    .busy(busy_s[1])
  );

  ram_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .WAIT_STATES(1)) u_dut2 (
    .clk(clk), .rst(rst), .memio(memio_s[2]), .rw(rw_s[2]), .addr(addr_s[2][3:0]),
    .data_in(din_s[2]), .data_out(dout2), .ready(ready_s[2]), .err(err_s[2]),
    .busy(busy_s[2])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 1;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : (d == 1) ? 200 : 16;
  endfunction

  function automatic logic [15:0] dmask(input int d);
    return (d == 2) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic logic [7:0] amask(input int d);
    return (d == 2) ? 8'h0F : 8'hFF;
  endfunction

  function automatic logic [15:0] dout(input int d);
    return (d == 0) ? {8'h00, dout0} : (d == 1) ? {8'h00, dout1} : dout2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected result of one access from the memory rules; updates the model.
  task automatic run_model(input int d, input logic r, input logic [7:0] a, input logic [15:0] wd,
                           output logic [15:0] ed, output logic ee);
    ee = (int'(a) >= depth_of(d));
    if (r) begin
      ed         = ee ? 16'h0 : mdl[d][a];
      last_rd[d] = ed;
    end else begin
      ed = last_rd[d];
      if (!ee) mdl[d][a] = wd & dmask(d);
    end
  endtask

  // One handshake on instance d; scrambles inputs while waiting, checks latency and pulse width.
  task automatic access(input int d, input logic r, input logic [7:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output logic e);
    int k = 0;
    bit seen = 1'b0;
    @(negedge clk);
    memio_s[d] = 1'b1; rw_s[d] = r; addr_s[d] = a; din_s[d] = wd;
    @(posedge clk);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (ready_s[d]) begin
        seen = 1'b1;
      end else begin
        memio_s[d] = 1'($urandom); rw_s[d] = 1'($urandom);
        addr_s[d] = 8'($urandom); din_s[d] = 16'($urandom);
      end
    end
    memio_s[d] = 1'b0;
    rd = dout(d) & dmask(d);
    e  = err_s[d];
    check($sformatf("latency dut%0d a=%0h", d, a), k, ws_of(d) + 1);
    @(negedge clk);
    check($sformatf("pulse end {ready,busy,err} dut%0d", d),
          {ready_s[d], busy_s[d], err_s[d]}, 3'b000);
  endtask

  // Reset all instances, check reset outputs, then time the clear sweep.
  task automatic reset_and_clear(input int hold);
    int cnt [3];
    int spurious = 0;
    int t = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) memio_s[d] = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset {ready,err,busy} dut%0d", d),
            {ready_s[d], err_s[d], busy_s[d]}, 3'b001);
      check($sformatf("reset data_out dut%0d", d), dout(d), 16'h0);
      cnt[d] = 0;
    end
    rst = 1'b0;
    while ((busy_s[0] || busy_s[1] || busy_s[2]) && t < 1000) begin
      for (int d = 0; d < 3; d++) begin
        if (busy_s[d]) cnt[d]++;
        if (ready_s[d]) spurious++;
      end
      @(negedge clk);
      t++;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("clear busy cycles dut%0d", d), cnt[d], depth_of(d));
      last_rd[d] = 16'h0;
      for (int i = 0; i < 256; i++) mdl[d][i] = 16'h0;
    end
    check("no ready during reset/clear", spurious, 0);
  endtask

  typedef struct {
    int          d;
    logic        r;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, ed;
    logic        e, ee;
    logic        r;
    logic [7:0]  a;
    logic [15:0] wd;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      memio_s[d] = 1'b0; rw_s[d] = 1'b1; addr_s[d] = 8'h0; din_s[d] = 16'h0;
    end

    //             d  r     a      wd        ed        ee
    tbl[0]  = '{0, 1'b1, 8'h01, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{0, 1'b0, 8'h01, 16'h00A9, 16'h0000, 1'b0};
    tbl[2]  = '{0, 1'b1, 8'h01, 16'h0000, 16'h00A9, 1'b0};
    tbl[3]  = '{1, 1'b0, 8'hC8, 16'h0055, 16'h0000, 1'b1};
    tbl[4]  = '{1, 1'b1, 8'hC8, 16'h0000, 16'h0000, 1'b1};
    tbl[5]  = '{1, 1'b1, 8'hC7, 16'h0000, 16'h0000, 1'b0};
    tbl[6]  = '{1, 1'b0, 8'hC7, 16'h0077, 16'h0000, 1'b0};
    tbl[7]  = '{1, 1'b1, 8'hC7, 16'h0000, 16'h0077, 1'b0};
    tbl[8]  = '{2, 1'b0, 8'h0F, 16'hBEEF, 16'h0000, 1'b0};
    tbl[9]  = '{2, 1'b0, 8'h00, 16'h1234, 16'h0000, 1'b0};
    tbl[10] = '{2, 1'b1, 8'h0F, 16'h0000, 16'hBEEF, 1'b0};
    tbl[11] = '{2, 1'b1, 8'h00, 16'h0000, 16'h1234, 1'b0};
    tbl[12] = '{1, 1'b1, 8'hC8, 16'h0000, 16'h0000, 1'b1};

    reset_and_clear(2);

    for (int i = 0; i < 13; i++) begin
      access(tbl[i].d, tbl[i].r, tbl[i].a, tbl[i].wd, rd, e);
      run_model(tbl[i].d, tbl[i].r, tbl[i].a, tbl[i].wd, ed, ee);
      check($sformatf("table[%0d] data_out", i), rd, tbl[i].ed);
      check($sformatf("table[%0d] err", i), e, tbl[i].ee);
    end
    // dut0 has idled through all the other table accesses.
    check("dut0 data_out held", dout(0), 16'h00A9);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        r  = 1'($urandom);
        a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
        a  = a & amask(d);
        wd = 16'($urandom) & dmask(d);
        access(d, r, a, wd, rd, e);
        run_model(d, r, a, wd, ed, ee);
        check($sformatf("rand dut%0d rw=%0d a=%0h data_out", d, r, a), rd, ed);
        check($sformatf("rand dut%0d rw=%0d a=%0h err", d, r, a), e, ee);
      end
    end

    // Reset while a write sits in WAIT on dut1: write must be dropped, no ready.
    @(negedge clk);
    memio_s[1] = 1'b1; rw_s[1] = 1'b0; addr_s[1] = 8'h10; din_s[1] = 16'h003C;
    @(posedge clk);
    @(negedge clk);
    memio_s[1] = 1'b0;
    check("dut1 busy in wait", busy_s[1], 1'b1);
    reset_and_clear(1);
    access(1, 1'b1, 8'h10, 16'h0, rd, e);
    check("dut1 read 0x10 after abort data_out", rd, 16'h0000);
    check("dut1 read 0x10 after abort err", e, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
